light_seq_decoder: RTL and testbench

- Receive-side companion to the three-sequence light sequencer FSM.
- Samples the sequencer's 4-bit state code stream and checks that it follows a legal sequence.
- Drives thermometer lamp outputs and the active sequence ID.
- Counts completed A/B/C sequences and flags protocol violations with a sticky error.

---
 rtl/light_seq_decoder.sv | 147 ++++++++++++++
 tb/tb_light_seq_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/light_seq_decoder.sv
// light_seq_decoder
//
// Receive-side checker for the three-sequence light sequencer. It samples the
// sequencer's 4-bit state code on every en=1 clock edge and checks that the
// stream follows a legal sequence:
//   A = 1,2,3,0   B = 4,5,6,0   C = 7,8,9,0
// It drives a thermometer lamp and the active sequence id, pulses done when
// a sequence completes, counts completions per sequence, and raises a sticky
// err on any protocol violation.
//
// All outputs are registered and reflect the code sampled at the previous
// en=1 edge.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   en       sample strobe; code is consumed only when en=1
//   code     sequencer state code (0 idle, 1-9 steps, 10-15 illegal)
//   err_clr  clears the sticky err (a violation on the same edge wins)
//   lamp     thermometer of the current step: 000, 001, 011, 111
//   seq_id   active sequence: 0 none, 1 A, 2 B, 3 C
//   done     one-cycle pulse when a sequence completes
//   err      sticky protocol-violation flag
//   cnt_a/b/c  saturating completed-sequence counters
module light_seq_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       code,
    input  logic             err_clr,
    output logic [2:0]       lamp,
    output logic [1:0]       seq_id,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResync
    } state_e;

    state_e     state_q;
    logic [1:0] step_q;  // 1..3 while in StRun
    logic [3:0] last_q;  // last accepted code while in StRun

    logic       is_start;
    logic [1:0] start_id;
    logic [3:0] exp_code;
    logic       hit;
    logic       viol;

    always_comb begin
        is_start = (code == 4'd1) || (code == 4'd4) || (code == 4'd7);
        start_id = (code == 4'd1) ? 2'd1 : ((code == 4'd4) ? 2'd2 : 2'd3);
        // After step 3 the only legal code is 0, which ends the sequence.
        exp_code = (step_q == 2'd3) ? 4'd0 : last_q + 4'd1;
        hit      = (code == exp_code);
        viol     = 1'b0;
        case (state_q)
            StIdle:  viol = en && (code != 4'd0) && !is_start;
            StRun:   viol = en && !hit;
            default: viol = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            step_q  <= 2'd0;
            last_q  <= 4'd0;
            lamp    <= 3'b000;
            seq_id  <= 2'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            cnt_c   <= '0;
        end else begin
            done <= 1'b0;

            // A violation on the same edge as err_clr keeps err set.
            if (viol) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            if (en) begin
                unique case (state_q)
                    StIdle: begin
                        if (is_start) begin
                            state_q <= StRun;
                            step_q  <= 2'd1;
                            last_q  <= code;
                            lamp    <= 3'b001;
                            seq_id  <= start_id;
                        end else if (code != 4'd0) begin
                            state_q <= StResync;
                            lamp    <= 3'b000;
                            seq_id  <= 2'd0;
                        end
                    end
                    StRun: begin
                        if (hit && (step_q != 2'd3)) begin
                            step_q <= step_q + 2'd1;
                            last_q <= code;
                            lamp   <= (step_q == 2'd1) ? 3'b011 : 3'b111;
                        end else if (hit) begin
                            state_q <= StIdle;
                            step_q  <= 2'd0;
                            lamp    <= 3'b000;
                            seq_id  <= 2'd0;
                            done    <= 1'b1;
                            case (seq_id)
                                2'd1:    if (cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
                                2'd2:    if (cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
                                2'd3:    if (cnt_c != '1) cnt_c <= cnt_c + CNT_W'(1);
                                default: ;
                            endcase
                        end else begin
                            state_q <= StResync;
                            step_q  <= 2'd0;
                            lamp    <= 3'b000;
                            seq_id  <= 2'd0;
                        end
                    end
                    StResync: begin
                        // Only a 0 code re-arms; never relock mid-sequence.
                        if (code == 4'd0) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_light_seq_decoder.sv
module tb_light_seq_decoder;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] code;
    logic       err_clr;

    logic [2:0] lamp;
    logic [1:0] seq_id;
    logic       done;
    logic       err;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    logic [2:0] lamp2;
    logic [1:0] seq_id2;
    logic       done2;
    logic       err2;
    logic [1:0] cnt_a2, cnt_b2, cnt_c2;

    int n_total;
    int n_bad;

    light_seq_decoder #(.CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .code    (code),
        .err_clr (err_clr),
        .lamp    (lamp),
        .seq_id  (seq_id),
        .done    (done),
        .err     (err),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b),
        .cnt_c   (cnt_c)
    );

    light_seq_decoder #(.CNT_W(2)) dut2 (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .code    (code),
        .err_clr (err_clr),
        .lamp    (lamp2),
        .seq_id  (seq_id2),
        .done    (done2),
        .err     (err2),
        .cnt_a   (cnt_a2),
        .cnt_b   (cnt_b2),
        .cnt_c   (cnt_c2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one sample and let it be taken on the next rising edge.
    task automatic drive(input logic e, input logic [3:0] c, input logic clr);
        en      = e;
        code    = c;
        err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b1;
        code  = 4'd3;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        en      = 1'b0;
        code    = 4'd0;
        err_clr = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [2:0] l, input logic [1:0] s,
                        input logic d, input logic e);
        check({tag, ".lamp"}, 32'(lamp), 32'(l));
        check({tag, ".seq_id"}, 32'(seq_id), 32'(s));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".err"}, 32'(err), 32'(e));
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        n_total = 0;
        n_bad   = 0;
        err_clr = 1'b0;
        en      = 1'b0;
        code    = 4'd0;
        reset   = 1'b1;
        @(posedge clk);
        do_reset();

        // Reset state
        outs("rst", 3'b000, 2'd0, 1'b0, 1'b0);
        check("rst.cnt_a", 32'(cnt_a), 0);
        check("rst.cnt_b", 32'(cnt_b), 0);
        check("rst.cnt_c", 32'(cnt_c), 0);

        // Sequence A
        drive(1, 4'd0, 0); outs("a0", 3'b000, 2'd0, 0, 0);
        drive(1, 4'd1, 0); outs("a1", 3'b001, 2'd1, 0, 0);
        drive(1, 4'd2, 0); outs("a2", 3'b011, 2'd1, 0, 0);
        drive(1, 4'd3, 0); outs("a3", 3'b111, 2'd1, 0, 0);
        drive(1, 4'd0, 0); outs("aend", 3'b000, 2'd0, 1, 0);
        check("a.cnt_a", 32'(cnt_a), 1);
        drive(0, 4'd0, 0); check("a.done_once", 32'(done), 0);

        // Back-to-back B then C
        drive(1, 4'd0, 0);
        drive(1, 4'd4, 0); outs("b1", 3'b001, 2'd2, 0, 0);
        drive(1, 4'd5, 0);
        drive(1, 4'd6, 0); outs("b3", 3'b111, 2'd2, 0, 0);
        drive(1, 4'd0, 0); outs("bend", 3'b000, 2'd0, 1, 0);
        drive(1, 4'd7, 0); outs("c1", 3'b001, 2'd3, 0, 0);
        drive(1, 4'd8, 0); outs("c2", 3'b011, 2'd3, 0, 0);
        drive(1, 4'd9, 0);
        drive(1, 4'd0, 0); outs("cend", 3'b000, 2'd0, 1, 0);
        check("bc.cnt_b", 32'(cnt_b), 1);
        check("bc.cnt_c", 32'(cnt_c), 1);

        // Skip violation, resync, recovery, err_clr
        drive(1, 4'd1, 0);
        drive(1, 4'd3, 0); outs("skip", 3'b000, 2'd0, 0, 1);
        drive(1, 4'd5, 0); outs("rs5", 3'b000, 2'd0, 0, 1);
        drive(1, 4'd6, 0); outs("rs6", 3'b000, 2'd0, 0, 1);
        check("rs.cnt_b", 32'(cnt_b), 1);
        drive(1, 4'd0, 0);
        drive(1, 4'd1, 0); outs("rec1", 3'b001, 2'd1, 0, 1);
        drive(1, 4'd2, 0);
        drive(1, 4'd3, 0);
        drive(1, 4'd0, 0); outs("recend", 3'b000, 2'd0, 1, 1);
        check("rec.cnt_a", 32'(cnt_a), 2);
        drive(0, 4'd0, 1); check("clr.err", 32'(err), 0);

        // en gaps with code held at 2
        drive(1, 4'd1, 0);
        drive(0, 4'd2, 0); outs("gap1", 3'b001, 2'd1, 0, 0);
        drive(0, 4'd2, 0); outs("gap2", 3'b001, 2'd1, 0, 0);
        drive(1, 4'd2, 0); outs("gap3", 3'b011, 2'd1, 0, 0);
        drive(1, 4'd3, 0);
        drive(1, 4'd0, 0); outs("gapend", 3'b000, 2'd0, 1, 0);
        check("gap.cnt_a", 32'(cnt_a), 3);

        // Illegal code in IDLE with err_clr on the same edge: set wins
        drive(1, 4'd12, 1); outs("setwins", 3'b000, 2'd0, 0, 1);
        drive(1, 4'd0, 1); check("clr2.err", 32'(err), 0);

        // Reset mid-RUN at step 2
        drive(1, 4'd1, 0);
        drive(1, 4'd2, 0); check("pre.lamp", 32'(lamp), 32'(3'b011));
        do_reset();
        outs("midrst", 3'b000, 2'd0, 0, 0);
        check("midrst.cnt_a", 32'(cnt_a), 0);
        check("midrst.cnt_b", 32'(cnt_b), 0);
        check("midrst.cnt_c", 32'(cnt_c), 0);
        // Idle after reset: a fresh start code must be accepted
        drive(1, 4'd1, 0); outs("postrst", 3'b001, 2'd1, 0, 0);

        // Saturation on the CNT_W=2 instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'd1, 0);
            drive(1, 4'd2, 0);
            drive(1, 4'd3, 0);
            drive(1, 4'd0, 0);
            check($sformatf("sat%0d.done", i), 32'(done2), 1);
            check($sformatf("sat%0d.cnt_a", i), 32'(cnt_a2), 32'(sat_exp[i]));
        end
        check("sat.err", 32'(err2), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
